// File: rtl/uart_rsa_pkg.sv
// Shared types and sizing helpers for the UART <-> RSA link controller.
// Optional feature macro used by this slice: RX_TIMEOUT_EN (see uart_rx_assembler).
package uart_rsa_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_HOLD = 2'd2,
    TX_WAIT = 2'd3
  } tx_state_e;

  localparam int unsigned WIDTH_DEF   = 256;
  localparam int unsigned TIMEOUT_DEF = 1000000;
  localparam int unsigned BYTES_DEF   = WIDTH_DEF / 8;

  function automatic int unsigned bytes_of(input int unsigned width);
    return width / 8;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_assembler.sv
// Collects LSB-first UART bits into one WIDTH-bit operand.
// RX_TIMEOUT_EN enables the inter-bit idle timeout that discards partial operands.
module uart_rx_assembler
  import uart_rsa_pkg::*;
#(
  parameter int unsigned WIDTH          = WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_bit,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] op_data,
  output logic             op_valid,
  output logic             rx_err
);

  localparam int unsigned BIT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [BIT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             timeout;

  assign sreg_next = {rx_bit, sreg[WIDTH-1:1]};
  assign last_bit  = (bit_cnt == BIT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      op_data  <= '0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      if (rx_ready) begin
        sreg <= sreg_next;
        if (last_bit) begin
          bit_cnt  <= '0;
          op_data  <= sreg_next;
          op_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (timeout) begin
        sreg    <= '0;
        bit_cnt <= '0;
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = cnt_w(TIMEOUT_CYCLES);

  // Down-counter of idle cycles left; fires on the TIMEOUT_CYCLES-th idle cycle mid-frame.
  logic [IDLE_W-1:0] idle_left;

  assign timeout = !rx_ready && (bit_cnt != '0) && (idle_left == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_left <= IDLE_W'(TIMEOUT_CYCLES - 1);
      rx_err    <= 1'b0;
    end else begin
      rx_err <= timeout;
      if (rx_ready || timeout) begin
        idle_left <= IDLE_W'(TIMEOUT_CYCLES - 1);
      end else if (bit_cnt != '0) begin
        idle_left <= idle_left - 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign rx_err  = 1'b0;
`endif

endmodule

// File: rtl/uart_rsa_link.sv
// Full-duplex link between the bit-serial UART and the RSA operand/result registers.
// RX assembly lives in uart_rx_assembler; RX_TIMEOUT_EN enables its idle timeout.
module uart_rsa_link
  import uart_rsa_pkg::*;
#(
  parameter int unsigned WIDTH          = WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_bit,
  input  logic             rx_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic [WIDTH-1:0] op_data,
  output logic             op_valid,
  input  logic [WIDTH-1:0] res_data,
  input  logic             res_valid,
  output logic             res_ready,
  output logic             tx_busy,
  output logic             rx_err
);

  localparam int unsigned BYTES  = bytes_of(WIDTH);
  localparam int unsigned BYTE_W = cnt_w(BYTES);

  tx_state_e         state;
  tx_state_e         state_next;
  logic [BYTE_W-1:0] byte_cnt;
  logic [WIDTH-1:0]  tx_sreg;
  logic              last_byte;

  uart_rx_assembler #(
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_bit   (rx_bit),
    .rx_ready (rx_ready),
    .op_data  (op_data),
    .op_valid (op_valid),
    .rx_err   (rx_err)
  );

  assign last_byte = (byte_cnt == BYTE_W'(BYTES - 1));
  assign res_ready = (state == TX_IDLE);
  assign tx_busy   = (state != TX_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE: if (res_valid) state_next = TX_SEND;
      TX_SEND: if (tx_ready)  state_next = TX_HOLD;
      // Guard cycle: the UART has not yet dropped tx_ready for the byte just started.
      TX_HOLD: state_next = TX_WAIT;
      TX_WAIT: if (tx_ready)  state_next = last_byte ? TX_IDLE : TX_SEND;
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= TX_IDLE;
      byte_cnt <= '0;
      tx_sreg  <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (res_valid) begin
            tx_sreg  <= res_data;
            byte_cnt <= '0;
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            tx_data  <= tx_sreg[7:0];
            tx_sreg  <= tx_sreg >> 8;
            tx_start <= 1'b1;
          end
        end
        TX_WAIT: begin
          if (tx_ready && !last_byte) byte_cnt <= byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rsa_link.sv
// Randomized self-checking bench for uart_rsa_link (WIDTH=16, TIMEOUT_CYCLES=50).
// Behavioural UART and word-level reference model; honours RX_TIMEOUT_EN when defined.
module tb_uart_rsa_link;

  localparam int W  = 16;
  localparam int TO = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx_bit = 1'b0;
  logic         rx_ready = 1'b0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic [W-1:0] op_data;
  logic         op_valid;
  logic [W-1:0] res_data = '0;
  logic         res_valid = 1'b0;
  logic         res_ready;
  logic         tx_busy;
  logic         rx_err;

  logic uart_idle = 1'b1;
  logic stall = 1'b0;
  assign tx_ready = uart_idle && !stall;

  uart_rsa_link #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_ready(rx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .op_data(op_data), .op_valid(op_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .tx_busy(tx_busy), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0] m_word;
  int           m_cnt = 0;
  int           m_idle = 0;
  logic [W-1:0] m_op = '0;
  bit           m_valid_pend = 0;
  bit           m_err_pend = 0;
  logic [7:0]   exp_tx_q[$];
  bit           prev_ready = 1'b1;

  // Observations for the literal checks
  int           valid_cnt = 0;
  int           err_cnt = 0;
  int           accepted = 0;
  logic [W-1:0] seen_ops[$];
  logic [7:0]   sent_q[$];

  // Behavioural UART transmitter: busy for a random number of cycles per byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && tx_start) begin
        sent_q.push_back(tx_data);
        @(posedge clk); #1;
        uart_idle = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 uart_idle = 1'b1;
      end
    end
  end

  // Compare process: outputs checked every cycle against the model, then model advances.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_op_data", op_data, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_res_ready", res_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_err", rx_err, 0);
        m_cnt = 0; m_word = '0; m_idle = 0; m_op = '0;
        m_valid_pend = 0; m_err_pend = 0;
        exp_tx_q.delete();
      end else begin
        chk("op_valid", op_valid, m_valid_pend);
        chk("op_data", op_data, m_op);
        chk("rx_err", rx_err, m_err_pend);
        chk("busy_vs_ready", tx_busy, !res_ready);
        if (exp_tx_q.size() > 0) chk("busy_while_pending", tx_busy, 1);
        if (tx_start) begin
          chk("start_only_when_ready", prev_ready, 1);
          if (exp_tx_q.size() == 0) chk("unexpected_tx_start", 1, 0);
          else chk("tx_data_byte", tx_data, exp_tx_q.pop_front());
        end
        if (op_valid) begin valid_cnt++; seen_ops.push_back(op_data); end
        if (rx_err) err_cnt++;

        m_valid_pend = 0;
        m_err_pend = 0;
        if (rx_ready) begin
          m_word[m_cnt] = rx_bit;
          m_cnt++;
          m_idle = 0;
          if (m_cnt == W) begin
            m_op = m_word; m_valid_pend = 1; m_cnt = 0; m_word = '0;
          end
        end else if (m_cnt != 0) begin
`ifdef RX_TIMEOUT_EN
          m_idle++;
          if (m_idle == TO) begin
            m_cnt = 0; m_word = '0; m_idle = 0; m_err_pend = 1;
          end
`endif
        end
        if (res_valid && res_ready) begin
          for (int b = 0; b < W / 8; b++) exp_tx_q.push_back(res_data[8*b +: 8]);
          accepted++;
        end
      end
      prev_ready = tx_ready;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi, input int gap_max);
    for (int i = lo; i <= hi; i++) begin
      rx_ready = 1'b1;
      rx_bit = w[i];
      cyc(1);
      rx_ready = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) cyc(1);
    end
  endtask

  task automatic wait_tx_idle(input string name);
    int n = 0;
    while (!(res_ready && tx_ready && exp_tx_q.size() == 0) && n < 3000) begin
      cyc(1); n++;
    end
    chk(name, (n < 3000), 1);
  endtask

  task automatic offer(input logic [W-1:0] w);
    res_data = w;
    res_valid = 1'b1;
    cyc(1);
    res_valid = 1'b0;
  endtask

  int v0, s0, a0, e0;

  initial begin
    cyc(3);
    rst = 1'b1;
    chk("first_cycle_res_ready", res_ready, 1);
    cyc(2);

    // Operand with gaps: no pulse until the 16th bit.
    v0 = valid_cnt;
    send_bits(16'hA53C, 0, 14, 3);
    cyc(3);
    chk("no_early_valid", valid_cnt, v0);
    send_bits(16'hA53C, 15, 15, 0);
    cyc(2);
    chk("a53c_pulses", valid_cnt, v0 + 1);
    chk("a53c_value", seen_ops[$], 16'hA53C);

    // Back-to-back strobes for two words.
    v0 = valid_cnt;
    send_bits(16'h1234, 0, 15, 0);
    send_bits(16'hFFFF, 0, 15, 0);
    cyc(2);
    chk("b2b_pulses", valid_cnt, v0 + 2);
    chk("b2b_word0", seen_ops[seen_ops.size() - 2], 16'h1234);
    chk("b2b_word1", seen_ops[$], 16'hFFFF);

    // Result transmission.
    s0 = sent_q.size();
    offer(16'hBEEF);
    chk("beef_busy", tx_busy, 1);
    wait_tx_idle("beef_done_in_time");
    chk("beef_byte_count", sent_q.size(), s0 + 2);
    chk("beef_byte0", sent_q[s0], 8'hEF);
    chk("beef_byte1", sent_q[s0 + 1], 8'hBE);
    cyc(1);
    chk("beef_res_ready_after", res_ready, 1);

    // Stall in SEND, offer while busy is ignored.
    s0 = sent_q.size();
    a0 = accepted;
    stall = 1'b1;
    offer(16'h1357);
    cyc(5);
    offer(16'h9999);
    cyc(200);
    chk("stall_no_start", sent_q.size(), s0);
    chk("stall_still_busy", tx_busy, 1);
    stall = 1'b0;
    wait_tx_idle("stall_done_in_time");
    chk("stall_accepted", accepted, a0 + 1);
    chk("stall_byte_count", sent_q.size(), s0 + 2);
    chk("stall_byte0", sent_q[s0], 8'h57);
    chk("stall_byte1", sent_q[s0 + 1], 8'h13);

    // Partial frame followed by a long idle gap.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(16'h00FF, 0, 4, 0);
    cyc(60);
`ifdef RX_TIMEOUT_EN
    chk("timeout_err_pulse", err_cnt, e0 + 1);
    chk("timeout_no_valid", valid_cnt, v0);
    send_bits(16'h00FF, 0, 15, 0);
`else
    chk("no_timeout_err", err_cnt, e0);
    send_bits(16'h00FF, 5, 15, 0);
`endif
    cyc(2);
    chk("after_gap_pulses", valid_cnt, v0 + 1);
    chk("after_gap_value", seen_ops[$], 16'h00FF);

    // Randomized concurrent RX and TX traffic.
    fork
      begin
        for (int k = 0; k < 8; k++) send_bits(W'($urandom), 0, W - 1, 3);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          wait_tx_idle("rand_tx_idle");
          cyc($urandom_range(0, 10));
          offer(W'($urandom));
        end
      end
    join
    wait_tx_idle("rand_tx_final");

    // Reset mid-frame during a transmission.
    send_bits(16'h5AA5, 0, 6, 0);
    offer(16'hCAFE);
    cyc(4);
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    chk("post_reset_res_ready", res_ready, 1);
    chk("post_reset_tx_busy", tx_busy, 0);
    v0 = valid_cnt;
    send_bits(16'hC0DE, 0, 15, 1);
    cyc(2);
    chk("post_reset_pulses", valid_cnt, v0 + 1);
    chk("post_reset_value", seen_ops[$], 16'hC0DE);
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
